// File: rtl/sys_out_deskew.sv
// sys_out_deskew
//   Receive-side deskew for systolic-array outputs. Each output row leaves the
//   array skewed: lane k of a row arrives k cycles after lane 0. Every lane is
//   delayed by NUM_LANES-1-k registers so that all lanes of one row line up in
//   the same cycle. Only complete rows (all lanes valid) are written into a row
//   FIFO. The FIFO is drained by a valid/ready consumer.
//
// Ports
//   clk         clock
//   rstn        synchronous active-low reset
//   lane_data   skewed lane data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   lane_valid  per-lane valid, skewed like the data
//   out_data    aligned row at the FIFO head, same lane packing
//   out_valid   FIFO holds at least one row
//   out_ready   consumer accepts the head row
//   fifo_count  number of rows held
//   full        fifo_count == OUT_DEPTH (advisory, upstream cannot stall)
//   align_err   sticky: a partially valid aligned row was seen
//   overflow    sticky: a complete row was dropped because the FIFO was full
//   err_clr     clears both sticky flags (a same-cycle new error wins)
module sys_out_deskew #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned OUT_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   lane_data,
  input  logic [NUM_LANES-1:0]              lane_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(OUT_DEPTH):0]        fifo_count,
  output logic                              full,
  output logic                              align_err,
  output logic                              overflow,
  input  logic                              err_clr
);

  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = NUM_LANES * DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // Deskew delay lines
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] al_data [NUM_LANES];
  logic [NUM_LANES-1:0]  al_valid;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam int unsigned D = NUM_LANES - 1 - k;

    if (D == 0) begin : g_pass
      // Last lane arrives latest, so it is used directly.
      assign al_data[k]  = lane_data[k*DATA_WIDTH +: DATA_WIDTH];
      assign al_valid[k] = lane_valid[k];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sd [D];
      logic [D-1:0]          sv;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int unsigned i = 0; i < D; i++) begin
            sd[i] <= '0;
          end
          sv <= '0;
        end else begin
          sd[0] <= lane_data[k*DATA_WIDTH +: DATA_WIDTH];
          sv[0] <= lane_valid[k];
          for (int unsigned i = 1; i < D; i++) begin
            sd[i] <= sd[i-1];
            sv[i] <= sv[i-1];
          end
        end
      end

      assign al_data[k]  = sd[D-1];
      assign al_valid[k] = sv[D-1];
    end
  end

  logic [RW-1:0] row_data;

  always_comb begin
    row_data = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      row_data[k*DATA_WIDTH +: DATA_WIDTH] = al_data[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Row qualification
  // ---------------------------------------------------------------------------
  logic row_v;
  logic row_partial;

  assign row_v       = &al_valid;
  assign row_partial = (|al_valid) && !row_v;

  // ---------------------------------------------------------------------------
  // Row FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          drop;

  assign out_valid = (fifo_count != '0);
  assign full      = (fifo_count == CW'(OUT_DEPTH));
  assign out_data  = mem[rptr];

  assign pop  = out_valid && out_ready;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push = row_v && (!full || pop);
  assign drop = row_v && full && !pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= row_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      align_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (row_partial) begin
        align_err <= 1'b1;
      end else if (err_clr) begin
        align_err <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sys_out_deskew.sv
module tb_sys_out_deskew;

  localparam int W = 8;
  localparam int N = 4;
  localparam int DEPTH = 4;
  localparam int PLAN = 4096;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   lane_data;
  logic [3:0]    lane_valid;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fifo_count;
  logic          full;
  logic          align_err;
  logic          overflow;
  logic          err_clr;

  sys_out_deskew #(
    .DATA_WIDTH (W),
    .NUM_LANES  (N),
    .OUT_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .full       (full),
    .align_err  (align_err),
    .overflow   (overflow),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // Input schedule: what is driven on the lane inputs in each cycle.
  logic [31:0] plan_d [PLAN];
  logic [3:0]  plan_v [PLAN];

  // Reference model state.
  logic [31:0] q [$];
  logic        m_aerr;
  logic        m_ovf;
  int          last_rst;
  int          n_popped;
  int          cyc;

  int total;
  int bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Schedule a row starting at cycle t0: lane k is driven at t0+k.
  task automatic add_row(input int t0, input logic [31:0] data, input logic [3:0] mask);
    for (int k = 0; k < N; k++) begin
      plan_v[t0+k][k]       = mask[k];
      plan_d[t0+k][k*W +: W] = data[k*W +: W];
    end
  endtask

  // Model: the row seen by the FIFO at cycle c takes lane k from the input of
  // cycle c-(N-1-k); inputs at or before the last reset cycle never arrive.
  task automatic model_edge();
    logic [3:0]  av;
    logic [31:0] ad;
    bit          do_pop;
    bit          was_full;
    bit          rowv;
    bit          part;
    bit          drop;
    if (!rstn) begin
      q.delete();
      m_aerr   = 1'b0;
      m_ovf    = 1'b0;
      last_rst = cyc;
      return;
    end
    av = '0;
    ad = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = cyc - (N - 1 - k);
      if (j >= 0 && j > last_rst) begin
        av[k]        = plan_v[j][k];
        ad[k*W +: W] = plan_d[j][k*W +: W];
      end
    end
    rowv     = (av == 4'hF);
    part     = (av != 4'h0) && !rowv;
    do_pop   = (q.size() > 0) && out_ready;
    was_full = (q.size() == DEPTH);
    drop     = rowv && was_full && !do_pop;
    if (do_pop) begin
      void'(q.pop_front());
      n_popped++;
    end
    if (rowv && !drop) q.push_back(ad);
    if (part) m_aerr = 1'b1;
    else if (err_clr) m_aerr = 1'b0;
    if (drop) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
  endtask

  task automatic tick();
    lane_data  = plan_d[cyc];
    lane_valid = plan_v[cyc];
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("count", 64'(fifo_count), 64'(q.size()));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("align_err", 64'(align_err), 64'(m_aerr));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (q.size() > 0) check("out_data", 64'(out_data), 64'(q[0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int t;
    int p0;
    for (int i = 0; i < PLAN; i++) begin
      plan_d[i] = '0;
      plan_v[i] = '0;
    end
    total = 0; bad = 0; cyc = 0; last_rst = -1; n_popped = 0;
    m_aerr = 1'b0; m_ovf = 1'b0;
    rstn = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    lane_data = '0; lane_valid = '0;

    // Reset state
    run(2);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    rstn = 1'b1;
    run(2);

    // Single skewed row: visible N cycles after lane 0
    t = cyc;
    add_row(t, 32'h13121110, 4'hF);
    run(4);
    check("row1_valid", 64'(out_valid), 64'h1);
    check("row1_data", 64'(out_data), 64'h13121110);
    check("row1_count", 64'(fifo_count), 64'h1);
    out_ready = 1'b1;
    run(3);

    // Fill, then one more row while stalled -> overflow, head unchanged
    out_ready = 1'b0;
    t = cyc;
    for (int i = 0; i < 5; i++) add_row(t + i, 32'hC0C0C000 + i, 4'hF);
    run(9);
    check("ovf_count", 64'(fifo_count), 64'h4);
    check("ovf_flag", 64'(overflow), 64'h1);
    check("ovf_head", 64'(out_data), 64'hC0C0C000);
    out_ready = 1'b1;
    run(5);
    err_clr = 1'b1;
    run(1);
    err_clr = 1'b0;
    check("ovf_clr", 64'(overflow), 64'h0);

    // Full FIFO, 5th row arrives in the same cycle as a pop -> accepted
    out_ready = 1'b0;
    t = cyc;
    for (int i = 0; i < 5; i++) add_row(t + i, 32'hD0D0D000 + i, 4'hF);
    run(7);
    check("fp_full", 64'(full), 64'h1);
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    check("fp_count", 64'(fifo_count), 64'h4);
    check("fp_ovf", 64'(overflow), 64'h0);
    check("fp_head", 64'(out_data), 64'hD0D0D001);
    out_ready = 1'b1;
    run(5);

    // Partial row (lane 2 missing) -> align_err, no push; clear; good row
    out_ready = 1'b0;
    t = cyc;
    add_row(t, 32'hEEEEEEEE, 4'b1011);
    run(4);
    check("al_flag", 64'(align_err), 64'h1);
    check("al_count", 64'(fifo_count), 64'h0);
    err_clr = 1'b1;
    run(1);
    err_clr = 1'b0;
    check("al_clr", 64'(align_err), 64'h0);
    t = cyc;
    add_row(t, 32'h44332211, 4'hF);
    run(4);
    check("al_good", 64'(out_data), 64'h44332211);
    out_ready = 1'b1;
    run(2);

    // 8 rows with out_ready toggling -> pointer wrap, all rows out
    p0 = n_popped;
    t = cyc;
    for (int i = 0; i < 8; i++) add_row(t + 2*i, 32'hA5000000 + 32'(i * 16'h0101), 4'hF);
    for (int i = 0; i < 30; i++) begin
      out_ready = i[0] ? 1'b0 : 1'b1;
      tick();
    end
    check("tog_popped", 64'(n_popped - p0), 64'h8);
    check("tog_err", 64'({align_err, overflow}), 64'h0);

    // Reset with 2 rows stored and 1 in flight
    out_ready = 1'b0;
    t = cyc;
    for (int i = 0; i < 3; i++) add_row(t + i, 32'hB0B0B000 + i, 4'hF);
    run(5);
    check("rs_before", 64'(fifo_count), 64'h2);
    for (int i = cyc; i < cyc + 8; i++) begin
      plan_v[i] = '0;
      plan_d[i] = '0;
    end
    rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    check("rs_valid", 64'(out_valid), 64'h0);
    check("rs_count", 64'(fifo_count), 64'h0);
    check("rs_flags", 64'({align_err, overflow}), 64'h0);
    run(6);
    check("rs_inflight", 64'(out_valid), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [3:0] m;
        m = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
        add_row(cyc, $urandom, m);
      end
      out_ready = 1'($urandom);
      err_clr   = ($urandom_range(0, 9) == 0);
      tick();
    end
    err_clr = 1'b0;
    out_ready = 1'b1;
    run(12);
    check("end_empty", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
